// File: rtl/snoop_bus_ctrl_pkg.sv
// Shared types for the dual-CPU snooping bus controller.
//   bus_op_t    : operation broadcast on BOCI[12:11]
//   datasel_t   : data source reported to the requesting CPU
//   bus_state_t : controller FSM states
//   req_op()    : per-CPU request priority (invalidate > write > read)
package common;

  localparam int unsigned NCPU   = 2;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_INV   = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    DS_NONE  = 2'b00,
    DS_OWN   = 2'b01,
    DS_OTHER = 2'b10,
    DS_MEM   = 2'b11
  } datasel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_WAIT_RSP,
    ST_GRANT,
    ST_RELEASE
  } bus_state_t;

  function automatic bus_op_t req_op(input logic rd, input logic wr, input logic inv);
    bus_op_t op;
    op = OP_IDLE;
    if (inv)     op = OP_INV;
    else if (wr) op = OP_WRITE;
    else if (rd) op = OP_READ;
    return op;
  endfunction

endpackage

// File: rtl/snoop_bus_ctrl_if.sv
// Bus bundle between the two CPU caches and snoop_bus_ctrl.
//   master : CPU side, drives requests, addresses and snoop responses
//   slave  : controller side, drives grants, snoop strobes and broadcasts
// Index i of every 2-wide field refers to CPU i.
interface snoop_bus_ctrl_if;
  import common::*;

  logic [NCPU-1:0]             read_miss;
  logic [NCPU-1:0]             write_miss;
  logic [NCPU-1:0]             invalidate;
  logic [NCPU-1:0][ADDR_W-1:0] BICO;
  logic [NCPU-1:0]             cpu_search_found;
  logic [NCPU-1:0][DATA_W-1:0] send_other_proc_data;

  logic [NCPU-1:0]             grant;
  logic [NCPU-1:0]             cpu_search;
  logic [NCPU-1:0][ADDR_W+1:0] BOCI;
  logic [NCPU-1:0][1:0]        cpu_datasel;
  logic [NCPU-1:0]             invalidate_from_other_cpu;
  logic [NCPU-1:0][DATA_W-1:0] other_proc_data;
  logic                        busy;

  modport master (
    output read_miss, write_miss, invalidate, BICO, cpu_search_found, send_other_proc_data,
    input  grant, cpu_search, BOCI, cpu_datasel, invalidate_from_other_cpu, other_proc_data, busy
  );

  modport slave (
    input  read_miss, write_miss, invalidate, BICO, cpu_search_found, send_other_proc_data,
    output grant, cpu_search, BOCI, cpu_datasel, invalidate_from_other_cpu, other_proc_data, busy
  );
endinterface

// File: rtl/snoop_bus_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst_n   : clock, async active-low reset
//   req[1:0]     : request per CPU
//   update       : commit the current winner as last-granted
//   winner       : CPU chosen for the current request pattern
//   last_granted : CPU most recently committed (resets to CPU1)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       winner,
  output logic       last_granted
);
  logic last_q, last_d;

  always_comb begin
    winner = 1'b0;
    if (req == 2'b11)         winner = ~last_q;
    else if (req == 2'b10)    winner = 1'b1;
    last_d = last_q;
    if (update) last_d = winner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  assign last_granted = last_q;
endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snooping bus controller for two CPU caches.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of snoop_bus_ctrl_if (requests in; grant,
//                snoop strobe, broadcast, data select and busy out)
// A request is latched in IDLE, broadcast to the other CPU in SNOOP, answered
// (or timed out after SNOOP_TO cycles) in WAIT_RSP, granted for one cycle and
// then held in RELEASE until the requester drops its request.
module snoop_bus_ctrl
  import common::*;
#(
  parameter int unsigned SNOOP_TO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  snoop_bus_ctrl_if.slave  bus
);
  bus_state_t              state_q, state_d;
  bus_op_t                 op_q, op_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    hit_q, hit_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [NCPU-1:0]         req_vec;
  logic                    arb_win, arb_last, arb_update;
  logic                    own, oth;
  datasel_t                sel;

  logic [NCPU-1:0]             grant_c, search_c, inv_c;
  logic [NCPU-1:0][ADDR_W+1:0] boci_c;
  logic [NCPU-1:0][1:0]        ds_c;
  logic [NCPU-1:0][DATA_W-1:0] opd_c;

  assign req_vec = bus.read_miss | bus.write_miss | bus.invalidate;

  rr_arb2 u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req_vec),
    .update       (arb_update),
    .winner       (arb_win),
    .last_granted (arb_last)
  );

  // The arbiter commits on selection, so outside IDLE its last-granted
  // output is the owner of the transaction in flight.
  assign own = arb_last;
  assign oth = ~arb_last;

  always_comb begin
    sel = DS_MEM;
    if (op_q == OP_INV) sel = DS_NONE;
    else if (hit_q)     sel = DS_OTHER;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    hit_d      = hit_q;
    cnt_d      = cnt_q;
    arb_update = 1'b0;
    grant_c    = '0;
    search_c   = '0;
    inv_c      = '0;
    boci_c     = '0;
    ds_c       = '0;
    opd_c      = '0;

    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          arb_update = 1'b1;
          op_d       = req_op(bus.read_miss[arb_win], bus.write_miss[arb_win],
                              bus.invalidate[arb_win]);
          addr_d     = bus.BICO[arb_win];
          data_d     = '0;
          hit_d      = 1'b0;
          cnt_d      = '0;
          state_d    = ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        boci_c[oth] = {op_q, addr_q};
        if (op_q == OP_INV) begin
          inv_c[oth] = 1'b1;
          state_d    = ST_GRANT;
        end else begin
          search_c[oth] = 1'b1;
          cnt_d         = '0;
          state_d       = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (bus.cpu_search_found[oth]) begin
          data_d  = bus.send_other_proc_data[oth];
          hit_d   = 1'b1;
          state_d = ST_GRANT;
        end else if (cnt_q == CNT_W'(SNOOP_TO - 1)) begin
          state_d = ST_GRANT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GRANT: begin
        grant_c[own] = 1'b1;
        ds_c[own]    = sel;
        opd_c[own]   = data_q;
        if (op_q == OP_WRITE) inv_c[oth] = 1'b1;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        ds_c[own] = sel;
        if (!req_vec[own]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant                     = grant_c;
  assign bus.cpu_search                = search_c;
  assign bus.BOCI                      = boci_c;
  assign bus.cpu_datasel               = ds_c;
  assign bus.invalidate_from_other_cpu = inv_c;
  assign bus.other_proc_data           = opd_c;
  assign bus.busy                      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
module tb_snoop_bus_ctrl;
  localparam int unsigned SNOOP_TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snoop_bus_ctrl_if bus ();

  snoop_bus_ctrl #(.SNOOP_TO(SNOOP_TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  rd, wr, inv, fnd;
    logic [10:0] b0, b1;
    logic [15:0] d0, d1;
    logic [1:0]  e_grant, e_search, e_invo;
    logic [12:0] e_boci0, e_boci1;
    logic [3:0]  e_ds;
    logic [15:0] e_opd0, e_opd1;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic r, input logic [1:0] rd, input logic [1:0] wr,
                     input logic [1:0] inv, input logic [10:0] b0, input logic [10:0] b1,
                     input logic [1:0] fnd, input logic [15:0] d0, input logic [15:0] d1,
                     input logic [1:0] g, input logic [1:0] srch, input logic [1:0] io,
                     input logic [12:0] bo0, input logic [12:0] bo1, input logic [3:0] ds,
                     input logic [15:0] o0, input logic [15:0] o1, input logic bsy);
    vec_t v;
    v.rst_n = r;  v.rd = rd;  v.wr = wr;  v.inv = inv;  v.b0 = b0;  v.b1 = b1;
    v.fnd = fnd;  v.d0 = d0;  v.d1 = d1;
    v.e_grant = g;  v.e_search = srch;  v.e_invo = io;  v.e_boci0 = bo0;  v.e_boci1 = bo1;
    v.e_ds = ds;  v.e_opd0 = o0;  v.e_opd1 = o1;  v.e_busy = bsy;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [1:0] rd, input logic [1:0] wr, input logic [1:0] inv,
                       input logic [10:0] b0, input logic [10:0] b1, input logic [1:0] fnd,
                       input logic [15:0] d0, input logic [15:0] d1);
    bus.read_miss  = rd;
    bus.write_miss = wr;
    bus.invalidate = inv;
    bus.BICO[0] = b0;
    bus.BICO[1] = b1;
    bus.cpu_search_found = fnd;
    bus.send_other_proc_data[0] = d0;
    bus.send_other_proc_data[1] = d1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " grant"},  {30'd0, bus.grant}, 32'd0);
    chk({tag, " search"}, {30'd0, bus.cpu_search}, 32'd0);
    chk({tag, " invo"},   {30'd0, bus.invalidate_from_other_cpu}, 32'd0);
    chk({tag, " boci"},   {6'd0, bus.BOCI[1], bus.BOCI[0]}, 32'd0);
    chk({tag, " ds"},     {28'd0, bus.cpu_datasel}, 32'd0);
    chk({tag, " opd"},    {bus.other_proc_data[1], bus.other_proc_data[0]}, 32'd0);
    chk({tag, " busy"},   {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held: everything quiet; then released with no requests.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("in_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d grant", c), {30'd0, bus.grant}, 32'd0);
      chk($sformatf("idle%0d busy", c),  {31'd0, bus.busy}, 32'd0);
    end

    //   r  rd    wr    inv   b0      b1      fnd   d0       d1         grant srch  invo  boci0     boci1     ds       opd0     opd1     busy
    // CPU0 read miss, CPU1 hits in first WAIT_RSP cycle
    add(1, 2'b01, 2'b00, 2'b00, 'h155, 'h000, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 0);
    add(1, 2'b01, 2'b00, 2'b00, 'h155, 'h000, 2'b00, 'h0000, 'h0000,    2'b00, 2'b10, 2'b00, 'h0000, 'h0955, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b01, 2'b00, 2'b00, 'h155, 'h000, 2'b10, 'h0000, 'hBEEF,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b01, 2'b00, 2'b00, 'h155, 'h000, 2'b00, 'h0000, 'h0000,    2'b01, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0010, 'hBEEF, 'h0000, 1);
    add(1, 2'b00, 2'b00, 2'b00, 'h000, 'h000, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0010, 'h0000, 'h0000, 1);
    add(1, 2'b00, 2'b00, 2'b00, 'h000, 'h000, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 0);
    // CPU1 write miss, no snoop hit: grant at cycle 2+SNOOP_TO
    add(1, 2'b00, 2'b10, 2'b00, 'h000, 'h2AA, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 0);
    add(1, 2'b00, 2'b10, 2'b00, 'h000, 'h2AA, 2'b00, 'h0000, 'h0000,    2'b00, 2'b01, 2'b00, 'h12AA, 'h0000, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b00, 2'b10, 2'b00, 'h000, 'h2AA, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b00, 2'b10, 2'b00, 'h000, 'h2AA, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b00, 2'b10, 2'b00, 'h000, 'h2AA, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b00, 2'b10, 2'b00, 'h000, 'h2AA, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b00, 2'b10, 2'b00, 'h000, 'h2AA, 2'b00, 'h0000, 'h0000,    2'b10, 2'b00, 2'b01, 'h0000, 'h0000, 4'b1100, 'h0000, 'h0000, 1);
    add(1, 2'b00, 2'b00, 2'b00, 'h000, 'h000, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b1100, 'h0000, 'h0000, 1);
    add(1, 2'b00, 2'b00, 2'b00, 'h000, 'h000, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 0);
    // Reset, then tie: CPU0 first, CPU1 held off and served next, next tie to CPU0
    add(0, 2'b00, 2'b00, 2'b00, 'h000, 'h000, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 0);
    add(1, 2'b11, 2'b00, 2'b00, 'h001, 'h7FF, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 0);
    add(1, 2'b11, 2'b00, 2'b00, 'h001, 'h7FF, 2'b00, 'h0000, 'h0000,    2'b00, 2'b10, 2'b00, 'h0000, 'h0801, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b11, 2'b00, 2'b00, 'h001, 'h7FF, 2'b10, 'h0000, 'h1234,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b11, 2'b00, 2'b00, 'h001, 'h7FF, 2'b00, 'h0000, 'h0000,    2'b01, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0010, 'h1234, 'h0000, 1);
    add(1, 2'b10, 2'b00, 2'b00, 'h000, 'h7FF, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0010, 'h0000, 'h0000, 1);
    add(1, 2'b10, 2'b00, 2'b00, 'h000, 'h7FF, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 0);
    add(1, 2'b10, 2'b00, 2'b00, 'h000, 'h7FF, 2'b00, 'h0000, 'h0000,    2'b00, 2'b01, 2'b00, 'h0FFF, 'h0000, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b10, 2'b00, 2'b00, 'h000, 'h7FF, 2'b01, 'h5678, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b10, 2'b00, 2'b00, 'h000, 'h7FF, 2'b00, 'h0000, 'h0000,    2'b10, 2'b00, 2'b00, 'h0000, 'h0000, 4'b1000, 'h0000, 'h5678, 1);
    add(1, 2'b00, 2'b00, 2'b00, 'h000, 'h000, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b1000, 'h0000, 'h0000, 1);
    add(1, 2'b11, 2'b00, 2'b00, 'h0AA, 'h055, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 0);
    add(1, 2'b11, 2'b00, 2'b00, 'h0AA, 'h055, 2'b00, 'h0000, 'h0000,    2'b00, 2'b10, 2'b00, 'h0000, 'h08AA, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b11, 2'b00, 2'b00, 'h0AA, 'h055, 2'b10, 'h0000, 'h0F0F,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b11, 2'b00, 2'b00, 'h0AA, 'h055, 2'b00, 'h0000, 'h0000,    2'b01, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0010, 'h0F0F, 'h0000, 1);
    add(1, 2'b10, 2'b00, 2'b00, 'h000, 'h055, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0010, 'h0000, 'h0000, 1);
    add(1, 2'b10, 2'b00, 2'b00, 'h000, 'h055, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 0);
    // Reset asserted while CPU1's transaction is in SNOOP aborts it at once
    add(0, 2'b00, 2'b00, 2'b00, 'h000, 'h000, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 0);
    // CPU0 invalidate with read miss also high: invalidate wins
    add(1, 2'b01, 2'b00, 2'b01, 'h3C3, 'h000, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 0);
    add(1, 2'b01, 2'b00, 2'b01, 'h3C3, 'h000, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b10, 'h0000, 'h1BC3, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b01, 2'b00, 2'b01, 'h3C3, 'h000, 2'b00, 'h0000, 'h0000,    2'b01, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b00, 2'b00, 2'b00, 'h000, 'h000, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 1);
    add(1, 2'b00, 2'b00, 2'b00, 'h000, 'h000, 2'b00, 'h0000, 'h0000,    2'b00, 2'b00, 2'b00, 'h0000, 'h0000, 4'b0000, 'h0000, 'h0000, 0);

    // Each row: inputs applied just after a rising edge, outputs checked on
    // the following falling edge.
    foreach (vq[i]) begin
      @(posedge clk); #1;
      rst_n = vq[i].rst_n;
      drive(vq[i].rd, vq[i].wr, vq[i].inv, vq[i].b0, vq[i].b1, vq[i].fnd, vq[i].d0, vq[i].d1);
      @(negedge clk);
      chk($sformatf("v%0d grant", i),  {30'd0, bus.grant}, {30'd0, vq[i].e_grant});
      chk($sformatf("v%0d search", i), {30'd0, bus.cpu_search}, {30'd0, vq[i].e_search});
      chk($sformatf("v%0d invo", i),   {30'd0, bus.invalidate_from_other_cpu}, {30'd0, vq[i].e_invo});
      chk($sformatf("v%0d boci", i),   {6'd0, bus.BOCI[1], bus.BOCI[0]}, {6'd0, vq[i].e_boci1, vq[i].e_boci0});
      chk($sformatf("v%0d ds", i),     {28'd0, bus.cpu_datasel}, {28'd0, vq[i].e_ds});
      chk($sformatf("v%0d opd", i),    {bus.other_proc_data[1], bus.other_proc_data[0]}, {vq[i].e_opd1, vq[i].e_opd0});
      chk($sformatf("v%0d busy", i),   {31'd0, bus.busy}, {31'd0, vq[i].e_busy});
    end

    // Reset pulsed during WAIT_RSP: outputs drop without a clock edge and no
    // grant follows once reset is released.
    @(posedge clk); #1;
    drive(2'b01, 0, 0, 'h100, 0, 0, 0, 0);
    @(posedge clk);   // IDLE -> SNOOP
    @(posedge clk);   // SNOOP -> WAIT_RSP
    #1;
    chk("wait_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < int'(SNOOP_TO) + 4; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d grant", c), {30'd0, bus.grant}, 32'd0);
      chk($sformatf("post_rst%0d busy", c),  {31'd0, bus.busy}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
